shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the shift-amount field.
REQ-003 The block SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  1  request offered.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_dir  input  1  0 = left, 1 = right.
REQ-008 The block SHALL have port req_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-009 The block SHALL have port req_amt  input  CNT_W  number of one-bit shift steps.
REQ-010 The block SHALL have port req_data  input  WIDTH  operand.
REQ-011 The block SHALL have port res_valid  output  1  result available.
REQ-012 The block SHALL have port res_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have port res_data  output  WIDTH  shifted result.
REQ-014 The block SHALL have port busy  output  1  high in SHIFT or DONE.

Function
REQ-015 The block SHALL implement FSM states IDLE, SHIFT, DONE; req_ready = (state == IDLE); res_valid = (state == DONE); busy = (state != IDLE).
REQ-016 A request SHALL be accepted on a rising edge where state == IDLE and req_valid = 1; at that edge the working register loads req_data and the step counter loads req_amt, with dir/mode latched.
REQ-017 On accept with req_amt = 0, next state SHALL be DONE with res_data = req_data; otherwise next state is SHIFT.
REQ-018 In SHIFT, each rising edge SHALL perform exactly one one-bit step and decrement the counter; the edge where counter == 1 SHALL move to DONE.
REQ-019 res_valid SHALL first be high after the (req_amt+1)th rising edge, counting the accept edge as the first.
REQ-020 Left step: logical and arithmetic SHALL fill bit 0 with 0; rotate SHALL move the old MSB into bit 0.
REQ-021 Right step: logical SHALL fill the MSB with 0; arithmetic SHALL replicate the old MSB; rotate SHALL move the old bit 0 into the MSB.
REQ-022 req_amt >= WIDTH SHALL NOT be clamped; the block runs req_amt steps (logical gives 0, arithmetic-right gives sign fill, rotate gives rotation by req_amt mod WIDTH).
REQ-023 In DONE, res_data and res_valid SHALL hold stable until res_ready = 1; that edge returns the FSM to IDLE.
REQ-024 req_valid SHALL be ignored while state != IDLE; no request is queued and none is overlapped with an in-flight operation.
REQ-025 req_dir, req_mode and req_data changes after accept SHALL NOT affect the in-flight operation.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, res_data = 0 and counter = 0, giving req_ready = 1, res_valid = 0 and busy = 0, regardless of state, including mid-SHIFT or in DONE.
REQ-027 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 Mode codes and state encodings SHALL live in shared include alu_defs.vh, reused by other ALU blocks.
REQ-029 The one-bit registered step (load, dir, mode, WIDTH-bit register) SHALL be sub-module shift_step; shift_sequencer holds the FSM, counter and handshake.

Verification
REQ-030 Bench SHALL cover: logical right, 10101010, amt 3 -> res_data 00010101, res_valid after edge 4.
REQ-031 Bench SHALL cover: arithmetic right, 11001101, amt 2 -> 11110011; rotate left, 11001101, amt 3 -> 01101110.
REQ-032 Bench SHALL cover: amt 0, 10101010 -> res_valid after the accept edge, res_data 10101010; also logical left, amt 9 -> 00000000.
REQ-033 Bench SHALL cover: res_ready held low 5 cycles in DONE -> res_valid/res_data stable, req_ready 0, a pulsed req_valid not accepted.
REQ-034 Bench SHALL cover: rst_n pulsed low mid-SHIFT (amt 6, step 3) -> outputs at reset values without waiting for clk; a new request after release completes correctly.
REQ-035 Bench SHALL cover: back-to-back requests with req_valid held high and res_ready = 1 -> each accepted only in IDLE, one result per request, in order.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared ALU definitions: shift mode codes, direction codes and sequencer state encodings.
// Other ALU blocks import this package so that every block uses the same codes.
package shift_sequencer_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;  // treated as logical

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_sequencer_step.sv
// Registered one-bit shifter: loads an operand with its direction and mode,
// then performs one shift/rotate step on every cycle that step_i is high.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q, data_d, stepped;
  logic             dir_q;
  logic [1:0]       mode_q;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stepped = data_q;
    if (dir_q == DIR_LEFT) begin
      stepped = {data_q[WIDTH-2:0], (mode_q == MODE_ROT) ? data_q[WIDTH-1] : 1'b0};
    end else begin
      case (mode_q)
        MODE_ARITH: stepped = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        MODE_ROT:   stepped = {data_q[0], data_q[WIDTH-1:1]};
        default:    stepped = {1'b0, data_q[WIDTH-1:1]};
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (step_i) begin
      data_d = stepped;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_LOGIC;
    end else begin
      data_q <= data_d;
      if (load_i) begin
        dir_q  <= dir_i;
        mode_q <= mode_i;
      end
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request in IDLE, runs req_amt one-bit steps,
// then holds the result in DONE until the consumer takes it.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [1:0]       req_mode,
  input  logic [CNT_W-1:0] req_amt,
  input  logic [WIDTH-1:0] req_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             step;

  assign accept = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = req_amt;
          state_d = (req_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (step),
    .dir_i  (req_dir),
    .mode_i (req_mode),
    .data_i (req_data),
    .data_o (res_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule
